// File: rtl/axi_lite_ctrl_regs_if.sv
// AXI4-Lite bus bundle for the crane controller register bank.
// Signal names follow the AXI4-Lite slave port names; clock and reset stay outside.
interface axi_lite_ctrl_regs_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic [2:0]            S_AXI_AWPROT;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [31:0]           S_AXI_WDATA;
    logic [3:0]            S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic [2:0]            S_AXI_ARPROT;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [31:0]           S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite slave: NUM_REGS RW control registers followed by NUM_STAT RO status words.
// Define AXI_LITE_CTRL_REGS_SLVERR_EN to answer ignored writes and out-of-range reads with SLVERR.
module axi_lite_ctrl_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS           = 8,
    parameter int NUM_STAT           = 2
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESETN,
    axi_lite_ctrl_regs_if.slave                      s_axi,
    output logic [32*NUM_REGS-1:0]                   ctrl_regs,
    output logic [NUM_REGS-1:0]                      reg_wr_pulse,
    // kept at least one word wide so NUM_STAT=0 still elaborates
    input  logic [32*(NUM_STAT > 0 ? NUM_STAT : 1)-1:0] stat_in
);
    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_ctrl [NUM_REGS];
    w_state_t                      r_wstate;
    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic [IDX_W-1:0]              r_widx;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]             r_wstrb;
    logic [NUM_REGS-1:0]           r_pulse;
    r_state_t                      r_rstate;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_commit;
    logic [IDX_W-1:0]              w_widx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wdata;
    logic [STRB_W-1:0]             w_wstrb;
    logic [IDX_W-1:0]              w_ridx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]                    w_rd_resp;
    logic                          w_unused;

    // Commit uses the bypassed AW/W fields so a same-cycle AW+W answers one cycle later.
    assign w_aw_hs  = r_awready & s_axi.S_AXI_AWVALID;
    assign w_w_hs   = r_wready & s_axi.S_AXI_WVALID;
    assign w_commit = (r_wstate == W_IDLE) & (w_aw_hs | ~r_awready) & (w_w_hs | ~r_wready);
    assign w_widx   = w_aw_hs ? s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : r_widx;
    assign w_wdata  = w_w_hs ? s_axi.S_AXI_WDATA : r_wdata;
    assign w_wstrb  = w_w_hs ? s_axi.S_AXI_WSTRB : r_wstrb;
    assign w_ridx   = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

`ifdef AXI_LITE_CTRL_REGS_SLVERR_EN
    logic w_wr_rw;
    assign w_wr_rw = (w_widx < IDX_W'(NUM_REGS));
`endif

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = 2'b00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ridx == IDX_W'(i)) w_rd_data = r_ctrl[i];
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (w_ridx == IDX_W'(NUM_REGS + j)) w_rd_data = stat_in[32*j +: 32];
        end
`ifdef AXI_LITE_CTRL_REGS_SLVERR_EN
        if (w_ridx >= IDX_W'(NUM_REGS + NUM_STAT)) w_rd_resp = 2'b10;
`endif
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_widx    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_pulse   <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_ctrl[i] <= '0;
        end else begin
            r_pulse <= '0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_widx    <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    end
                    if (w_w_hs) begin
                        r_wready <= 1'b0;
                        r_wdata  <= s_axi.S_AXI_WDATA;
                        r_wstrb  <= s_axi.S_AXI_WSTRB;
                    end
                    if (w_commit) begin
                        r_wstate <= W_RESP;
                        r_bvalid <= 1'b1;
`ifdef AXI_LITE_CTRL_REGS_SLVERR_EN
                        r_bresp  <= w_wr_rw ? 2'b00 : 2'b10;
`else
                        r_bresp  <= 2'b00;
`endif
                        // RO and out-of-range indices match no RW slot and are dropped here
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (w_widx == IDX_W'(i)) begin
                                r_pulse[i] <= 1'b1;
                                for (int k = 0; k < STRB_W; k++) begin
                                    if (w_wstrb[k]) r_ctrl[i][8*k +: 8] <= w_wdata[8*k +: 8];
                                end
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Reads sample r_ctrl before any same-cycle commit lands, so they see the old value.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_axi.S_AXI_ARVALID) begin
                        r_rstate  <= R_RESP;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_resp;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                    end
                end
                R_RESP: begin
                    if (s_axi.S_AXI_RREADY) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign ctrl_regs[32*gi +: 32] = r_ctrl[gi];
        end
    endgenerate

    assign reg_wr_pulse        = r_pulse;
    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign s_axi.S_AXI_RDATA   = r_rdata;

    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Bench for axi_lite_ctrl_regs: directed scenarios plus random traffic against an array model.
// Expected responses follow AXI_LITE_CTRL_REGS_SLVERR_EN the same way the design build does.
module tb_axi_lite_ctrl_regs;
    localparam int NR = 8;
    localparam int NS = 2;
`ifdef AXI_LITE_CTRL_REGS_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [32*NR-1:0] ctrl_regs;
    logic [NR-1:0]   reg_wr_pulse;
    logic [32*NS-1:0] stat_in;
    int              total = 0;
    int              bad = 0;
    logic [31:0]     m_regs [NR];

    axi_lite_ctrl_regs_if #(.ADDR_WIDTH(32)) bif ();

    axi_lite_ctrl_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32),
        .NUM_REGS(NR),
        .NUM_STAT(NS)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi        (bif),
        .ctrl_regs    (ctrl_regs),
        .reg_wr_pulse (reg_wr_pulse),
        .stat_in      (stat_in)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (idx < NR) return m_regs[idx[2:0]];
        if (idx == NR) return stat_in[31:0];
        if (idx == NR + 1) return stat_in[63:32];
        return 32'h0;
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [31:0] addr);
        return ((addr >> 2) >= NR + NS) ? ERR_RESP : 2'b00;
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [31:0] addr);
        return ((addr >> 2) >= NR) ? ERR_RESP : 2'b00;
    endfunction

    function automatic logic [NR-1:0] exp_pulse(input logic [31:0] addr);
        logic [NR-1:0] p;
        logic [31:0] idx;
        idx = addr >> 2;
        p = '0;
        if (idx < NR) p[idx[2:0]] = 1'b1;
        return p;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] idx;
        idx = addr >> 2;
        if (idx < NR)
            for (int k = 0; k < 4; k++)
                if (strb[k]) m_regs[idx[2:0]][8*k +: 8] = data[8*k +: 8];
    endfunction

    function automatic logic [32*NR-1:0] model_flat();
        logic [32*NR-1:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = m_regs[i];
        return f;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
    endfunction

    // ---------------- bus drivers (observe only; tests compare) ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int b_hold,
                             output logic [1:0] bresp, output logic [NR-1:0] p_or, output int p_cnt,
                             output int lat, output bit ok);
        int aw_at, w_at, hs_cyc, cyc;
        bit aw_sent, w_sent, aw_pend, w_pend, tmo;
        aw_at = (w_lead > 0) ? w_lead : 0;
        w_at  = (w_lead < 0) ? -w_lead : 0;
        p_or = '0; p_cnt = 0; lat = -1; ok = 1'b1; tmo = 1'b0; bresp = 2'bxx;
        hs_cyc = 0; cyc = 0;
        aw_sent = 1'b0; w_sent = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
        while (1) begin
            @(negedge clk);
            if (reg_wr_pulse != '0) begin p_or |= reg_wr_pulse; p_cnt++; end
            if (aw_pend) begin bif.S_AXI_AWVALID = 1'b0; aw_sent = 1'b1; aw_pend = 1'b0; end
            if (w_pend) begin bif.S_AXI_WVALID = 1'b0; w_sent = 1'b1; w_pend = 1'b0; end
            if (bif.S_AXI_BVALID) break;
            if (cyc > 40) begin tmo = 1'b1; break; end
            if (aw_sent && bif.S_AXI_AWREADY) ok = 1'b0;
            if (w_sent && bif.S_AXI_WREADY) ok = 1'b0;
            if (!aw_sent && cyc >= aw_at) begin
                bif.S_AXI_AWADDR = addr; bif.S_AXI_AWPROT = 3'($urandom); bif.S_AXI_AWVALID = 1'b1;
                if (bif.S_AXI_AWREADY) begin aw_pend = 1'b1; hs_cyc = cyc; end
            end
            if (!w_sent && cyc >= w_at) begin
                bif.S_AXI_WDATA = data; bif.S_AXI_WSTRB = strb; bif.S_AXI_WVALID = 1'b1;
                if (bif.S_AXI_WREADY) begin w_pend = 1'b1; hs_cyc = cyc; end
            end
            cyc++;
        end
        bif.S_AXI_AWVALID = 1'b0;
        bif.S_AXI_WVALID  = 1'b0;
        if (tmo) begin
            ok = 1'b0;
        end else begin
            lat = cyc - hs_cyc;
            bresp = bif.S_AXI_BRESP;
            if (!(aw_sent && w_sent)) ok = 1'b0;
            for (int h = 0; h < b_hold; h++) begin
                if (!bif.S_AXI_BVALID || bif.S_AXI_BRESP !== bresp || bif.S_AXI_AWREADY || bif.S_AXI_WREADY) ok = 1'b0;
                @(negedge clk);
                if (reg_wr_pulse != '0) begin p_or |= reg_wr_pulse; p_cnt++; end
            end
            if (!bif.S_AXI_BVALID || bif.S_AXI_BRESP !== bresp) ok = 1'b0;
            bif.S_AXI_BREADY = 1'b1;
            @(negedge clk);
            bif.S_AXI_BREADY = 1'b0;
            if (reg_wr_pulse != '0) begin p_or |= reg_wr_pulse; p_cnt++; end
            if (bif.S_AXI_BVALID || !bif.S_AXI_AWREADY || !bif.S_AXI_WREADY) ok = 1'b0;
        end
        $display("wr addr=%h data=%h strb=%h lead=%0d hold=%0d resp=%b pulse=%b lat=%0d ok=%0d",
                 addr, data, strb, w_lead, b_hold, bresp, p_or, lat, ok);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_hold,
                            output logic [31:0] rdata, output logic [1:0] rresp,
                            output int lat, output bit ok);
        int cyc;
        ok = 1'b1; lat = -1; rdata = 'x; rresp = 2'bxx;
        @(negedge clk);
        bif.S_AXI_ARADDR = addr; bif.S_AXI_ARPROT = 3'($urandom); bif.S_AXI_ARVALID = 1'b1;
        cyc = 0;
        while (!bif.S_AXI_ARREADY && cyc < 40) begin @(negedge clk); cyc++; end
        if (!bif.S_AXI_ARREADY) ok = 1'b0;
        @(negedge clk);
        bif.S_AXI_ARVALID = 1'b0;
        // status must have been sampled at the handshake, so move it now
        stat_in = {$urandom, $urandom};
        cyc = 1;
        while (!bif.S_AXI_RVALID && cyc < 40) begin @(negedge clk); cyc++; end
        if (bif.S_AXI_RVALID) begin
            lat = cyc;
            rdata = bif.S_AXI_RDATA; rresp = bif.S_AXI_RRESP;
            if (bif.S_AXI_ARREADY) ok = 1'b0;
            for (int h = 0; h < r_hold; h++) begin
                @(negedge clk);
                if (!bif.S_AXI_RVALID || bif.S_AXI_RDATA !== rdata || bif.S_AXI_RRESP !== rresp || bif.S_AXI_ARREADY) ok = 1'b0;
            end
            bif.S_AXI_RREADY = 1'b1;
            @(negedge clk);
            bif.S_AXI_RREADY = 1'b0;
            if (bif.S_AXI_RVALID || !bif.S_AXI_ARREADY) ok = 1'b0;
        end else begin
            ok = 1'b0;
        end
        $display("rd addr=%h hold=%0d data=%h resp=%b lat=%0d ok=%0d", addr, r_hold, rdata, rresp, lat, ok);
    endtask

    // ---------------- scenario state ----------------
    logic [1:0]    s_bresp, s_rresp;
    logic [NR-1:0] s_por;
    int            s_pcnt, s_wlat, s_rlat;
    bit            s_wok, s_rok;
    logic [31:0]   s_rdata, s_exp, s_addr, s_data, s_old;
    logic [3:0]    s_strb;

    task test_reset();
        rst_n = 1'b0;
        bif.S_AXI_AWADDR = '0; bif.S_AXI_AWPROT = '0; bif.S_AXI_AWVALID = 1'b0;
        bif.S_AXI_WDATA = '0; bif.S_AXI_WSTRB = '0; bif.S_AXI_WVALID = 1'b0; bif.S_AXI_BREADY = 1'b0;
        bif.S_AXI_ARADDR = '0; bif.S_AXI_ARPROT = '0; bif.S_AXI_ARVALID = 1'b0; bif.S_AXI_RREADY = 1'b0;
        stat_in = {$urandom, $urandom};
        model_reset();
        repeat (2) @(negedge clk);
        total++; if (bif.S_AXI_AWREADY !== 1'b1) begin bad++; $display("FAIL reset_awready got=%b want=1", bif.S_AXI_AWREADY); end
        total++; if (bif.S_AXI_WREADY !== 1'b1) begin bad++; $display("FAIL reset_wready got=%b want=1", bif.S_AXI_WREADY); end
        total++; if (bif.S_AXI_ARREADY !== 1'b1) begin bad++; $display("FAIL reset_arready got=%b want=1", bif.S_AXI_ARREADY); end
        total++; if (bif.S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL reset_bvalid got=%b want=0", bif.S_AXI_BVALID); end
        total++; if (bif.S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", bif.S_AXI_RVALID); end
        total++; if (bif.S_AXI_BRESP !== 2'b00) begin bad++; $display("FAIL reset_bresp got=%b want=00", bif.S_AXI_BRESP); end
        total++; if (bif.S_AXI_RRESP !== 2'b00) begin bad++; $display("FAIL reset_rresp got=%b want=00", bif.S_AXI_RRESP); end
        total++; if (bif.S_AXI_RDATA !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bif.S_AXI_RDATA); end
        total++; if (ctrl_regs !== '0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", ctrl_regs); end
        total++; if (reg_wr_pulse !== '0) begin bad++; $display("FAIL reset_pulse got=%b want=0", reg_wr_pulse); end
        rst_n = 1'b1;
    endtask

    task test_basic_write();
        axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, s_bresp, s_por, s_pcnt, s_wlat, s_wok);
        model_write(32'h04, 32'hDEADBEEF, 4'hF);
        total++; if (!s_wok) begin bad++; $display("FAIL basic_handshake got=0 want=1"); end
        total++; if (s_wlat !== 1) begin bad++; $display("FAIL basic_bvalid_latency got=%0d want=1", s_wlat); end
        total++; if (s_bresp !== 2'b00) begin bad++; $display("FAIL basic_bresp got=%b want=00", s_bresp); end
        total++; if (s_por !== 8'b0000_0010 || s_pcnt !== 1) begin bad++; $display("FAIL basic_pulse got=%b x%0d want=00000010 x1", s_por, s_pcnt); end
        total++; if (ctrl_regs[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_reg1 got=%h want=deadbeef", ctrl_regs[63:32]); end
        total++; if (ctrl_regs !== model_flat()) begin bad++; $display("FAIL basic_ctrl got=%h want=%h", ctrl_regs, model_flat()); end
        axi_read(32'h04, 0, s_rdata, s_rresp, s_rlat, s_rok);
        total++; if (s_rdata !== 32'hDEADBEEF || s_rresp !== 2'b00) begin bad++; $display("FAIL basic_readback got=%h/%b want=deadbeef/00", s_rdata, s_rresp); end
        total++; if (!s_rok || s_rlat !== 1) begin bad++; $display("FAIL basic_read_timing got=ok%0d lat%0d want=ok1 lat1", s_rok, s_rlat); end
    endtask

    task test_partial_write();
        axi_write(32'h04, 32'h11223344, 4'h5, 0, 1, s_bresp, s_por, s_pcnt, s_wlat, s_wok);
        model_write(32'h04, 32'h11223344, 4'h5);
        total++; if (ctrl_regs[63:32] !== 32'hDE22BE44) begin bad++; $display("FAIL partial_reg1 got=%h want=de22be44", ctrl_regs[63:32]); end
        total++; if (!s_wok || s_pcnt !== 1 || s_por !== 8'b0000_0010) begin bad++; $display("FAIL partial_pulse got=ok%0d %b x%0d want=ok1 00000010 x1", s_wok, s_por, s_pcnt); end
        // zero strobes still pulse but change nothing
        axi_write(32'h07, 32'hFFFFFFFF, 4'h0, 0, 0, s_bresp, s_por, s_pcnt, s_wlat, s_wok);
        total++; if (s_por !== 8'b0000_0010 || s_pcnt !== 1 || ctrl_regs !== model_flat()) begin bad++; $display("FAIL strb0_write got=%b x%0d reg1=%h want=00000010 x1 reg1=%h", s_por, s_pcnt, ctrl_regs[63:32], m_regs[1]); end
    endtask

    task test_w_before_aw();
        s_data = $urandom;
        axi_write(32'h1C, s_data, 4'hF, 3, 4, s_bresp, s_por, s_pcnt, s_wlat, s_wok);
        model_write(32'h1C, s_data, 4'hF);
        total++; if (!s_wok) begin bad++; $display("FAIL wfirst_stall_hold got=0 want=1"); end
        total++; if (s_pcnt !== 1 || s_por !== 8'b1000_0000) begin bad++; $display("FAIL wfirst_pulse got=%b x%0d want=10000000 x1", s_por, s_pcnt); end
        total++; if (s_wlat !== 1 || ctrl_regs !== model_flat()) begin bad++; $display("FAIL wfirst_commit got=lat%0d %h want=lat1 %h", s_wlat, ctrl_regs, model_flat()); end
        s_data = $urandom;
        axi_write(32'h00, s_data, 4'hF, -2, 2, s_bresp, s_por, s_pcnt, s_wlat, s_wok);
        model_write(32'h00, s_data, 4'hF);
        total++; if (!s_wok || s_pcnt !== 1 || ctrl_regs !== model_flat()) begin bad++; $display("FAIL awfirst_commit got=ok%0d x%0d %h want=ok1 x1 %h", s_wok, s_pcnt, ctrl_regs, model_flat()); end
    endtask

    task test_status();
        stat_in[31:0] = 32'hCAFE0001;
        axi_read(32'h20, 2, s_rdata, s_rresp, s_rlat, s_rok);
        total++; if (s_rdata !== 32'hCAFE0001 || s_rresp !== 2'b00) begin bad++; $display("FAIL stat0_read got=%h/%b want=cafe0001/00", s_rdata, s_rresp); end
        total++; if (!s_rok) begin bad++; $display("FAIL stat0_hold got=0 want=1"); end
        s_exp = exp_read(32'h24);
        axi_read(32'h27, 1, s_rdata, s_rresp, s_rlat, s_rok);
        total++; if (s_rdata !== s_exp || s_rresp !== 2'b00 || !s_rok) begin bad++; $display("FAIL stat_last_read got=%h/%b ok%0d want=%h/00 ok1", s_rdata, s_rresp, s_rok, s_exp); end
    endtask

    task test_errors();
        s_addr = 32'h20;
        for (int t = 0; t < 3; t++) begin
            s_addr = (t == 0) ? 32'h20 : (t == 1) ? 32'h28 : 32'h8000_0004;
            axi_write(s_addr, $urandom, 4'hF, 0, 0, s_bresp, s_por, s_pcnt, s_wlat, s_wok);
            total++; if (s_bresp !== ERR_RESP || !s_wok) begin bad++; $display("FAIL ignored_write_bresp addr=%h got=%b want=%b", s_addr, s_bresp, ERR_RESP); end
            total++; if (s_pcnt !== 0 || ctrl_regs !== model_flat()) begin bad++; $display("FAIL ignored_write_state addr=%h got=x%0d %h want=x0 %h", s_addr, s_pcnt, ctrl_regs, model_flat()); end
        end
        axi_read(32'h40, 0, s_rdata, s_rresp, s_rlat, s_rok);
        total++; if (s_rdata !== 32'h0 || s_rresp !== ERR_RESP) begin bad++; $display("FAIL oor_read_40 got=%h/%b want=0/%b", s_rdata, s_rresp, ERR_RESP); end
        axi_read(32'h28, 0, s_rdata, s_rresp, s_rlat, s_rok);
        total++; if (s_rdata !== 32'h0 || s_rresp !== ERR_RESP) begin bad++; $display("FAIL oor_read_28 got=%h/%b want=0/%b", s_rdata, s_rresp, ERR_RESP); end
    endtask

    task test_concurrent();
        for (int t = 0; t < 4; t++) begin
            s_addr = 32'($urandom_range(0, NR - 1)) << 2;
            s_data = $urandom;
            s_old = exp_read(s_addr);
            fork
                axi_write(s_addr, s_data, 4'hF, 0, 1, s_bresp, s_por, s_pcnt, s_wlat, s_wok);
                axi_read(s_addr, 0, s_rdata, s_rresp, s_rlat, s_rok);
            join
            model_write(s_addr, s_data, 4'hF);
            total++; if (s_rdata !== s_old || !s_rok || !s_wok) begin bad++; $display("FAIL same_cycle_read addr=%h got=%h want=%h", s_addr, s_rdata, s_old); end
            total++; if (ctrl_regs !== model_flat()) begin bad++; $display("FAIL same_cycle_write got=%h want=%h", ctrl_regs, model_flat()); end
        end
    endtask

    task test_random();
        for (int t = 0; t < 30; t++) begin
            s_addr = (32'($urandom_range(0, NR + NS + 2)) << 2) | 32'($urandom_range(0, 3));
            s_data = $urandom;
            s_strb = 4'($urandom);
            axi_write(s_addr, s_data, s_strb, $urandom_range(0, 6) - 3, $urandom_range(0, 3),
                      s_bresp, s_por, s_pcnt, s_wlat, s_wok);
            model_write(s_addr, s_data, s_strb);
            total++; if (!s_wok || s_bresp !== exp_bresp(s_addr)) begin bad++; $display("FAIL rand_write addr=%h got=ok%0d %b want=ok1 %b", s_addr, s_wok, s_bresp, exp_bresp(s_addr)); end
            total++; if (s_por !== exp_pulse(s_addr) || s_pcnt !== ((s_addr >> 2) < NR ? 1 : 0)) begin bad++; $display("FAIL rand_pulse addr=%h got=%b x%0d want=%b", s_addr, s_por, s_pcnt, exp_pulse(s_addr)); end
            total++; if (ctrl_regs !== model_flat()) begin bad++; $display("FAIL rand_ctrl got=%h want=%h", ctrl_regs, model_flat()); end
            s_addr = (32'($urandom_range(0, NR + NS + 2)) << 2) | 32'($urandom_range(0, 3));
            s_exp = exp_read(s_addr);
            axi_read(s_addr, $urandom_range(0, 3), s_rdata, s_rresp, s_rlat, s_rok);
            total++; if (!s_rok || s_rdata !== s_exp || s_rresp !== exp_rresp(s_addr)) begin bad++; $display("FAIL rand_read addr=%h got=%h/%b want=%h/%b", s_addr, s_rdata, s_rresp, s_exp, exp_rresp(s_addr)); end
        end
    endtask

    task test_async_reset();
        @(negedge clk);
        bif.S_AXI_AWADDR = 32'h0; bif.S_AXI_WDATA = 32'hFFFF_FFFF; bif.S_AXI_WSTRB = 4'hF;
        bif.S_AXI_AWVALID = 1'b1; bif.S_AXI_WVALID = 1'b1;
        bif.S_AXI_ARADDR = 32'h04; bif.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        bif.S_AXI_AWVALID = 1'b0; bif.S_AXI_WVALID = 1'b0; bif.S_AXI_ARVALID = 1'b0;
        total++; if (bif.S_AXI_BVALID !== 1'b1 || bif.S_AXI_RVALID !== 1'b1 || ctrl_regs[31:0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL prereset_busy got=b%b r%b %h want=b1 r1 ffffffff", bif.S_AXI_BVALID, bif.S_AXI_RVALID, ctrl_regs[31:0]); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bif.S_AXI_BVALID !== 1'b0 || bif.S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL async_reset_valids got=b%b r%b want=b0 r0", bif.S_AXI_BVALID, bif.S_AXI_RVALID); end
        total++; if (ctrl_regs !== '0 || !bif.S_AXI_AWREADY || !bif.S_AXI_ARREADY) begin bad++; $display("FAIL async_reset_state got=%h aw%b ar%b want=0 aw1 ar1", ctrl_regs, bif.S_AXI_AWREADY, bif.S_AXI_ARREADY); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bif.S_AXI_BREADY = 1'b1; bif.S_AXI_RREADY = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bif.S_AXI_BVALID !== 1'b0 || bif.S_AXI_RVALID !== 1'b0 || reg_wr_pulse !== '0) begin bad++; $display("FAIL postreset_quiet got=b%b r%b p%b want=b0 r0 p0", bif.S_AXI_BVALID, bif.S_AXI_RVALID, reg_wr_pulse); end
        bif.S_AXI_BREADY = 1'b0; bif.S_AXI_RREADY = 1'b0;
        s_data = $urandom;
        axi_write(32'h0C, s_data, 4'hF, 0, 0, s_bresp, s_por, s_pcnt, s_wlat, s_wok);
        model_write(32'h0C, s_data, 4'hF);
        axi_read(32'h0C, 0, s_rdata, s_rresp, s_rlat, s_rok);
        total++; if (!s_wok || !s_rok || s_rdata !== s_data || ctrl_regs !== model_flat()) begin bad++; $display("FAIL postreset_rw got=%h want=%h", s_rdata, s_data); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_partial_write();
        test_w_before_aw();
        test_status();
        test_errors();
        test_concurrent();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
